// File: rtl/ace_snoop_sequencer_if.sv
// Snoop-side bundle of the ACE snoop sequencer: AC/CR/CD channels plus the cache lookup port.
// slave = the sequencer's view, master = the interconnect/cache environment's view.
interface ace_snoop_sequencer_if #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineWidth = 128
);
    logic                 ac_valid_i;
    logic                 ac_ready_o;
    logic [AddrWidth-1:0] ac_addr_i;
    logic [3:0]           ac_snoop_i;

    logic                 cr_valid_o;
    logic                 cr_ready_i;
    logic [4:0]           cr_resp_o;

    logic                 cd_valid_o;
    logic                 cd_ready_i;
    logic [DataWidth-1:0] cd_data_o;
    logic                 cd_last_o;

    logic                 lookup_req_o;
    logic                 lookup_gnt_i;
    logic [AddrWidth-1:0] lookup_addr_o;
    logic [3:0]           lookup_snoop_o;
    logic                 lookup_rvalid_i;
    logic                 lookup_hit_i;
    logic                 lookup_dirty_i;
    logic                 lookup_shared_i;
    logic [LineWidth-1:0] lookup_line_i;

    logic                 busy_o;

    modport slave (
        input  ac_valid_i, ac_addr_i, ac_snoop_i,
        output ac_ready_o,
        output cr_valid_o, cr_resp_o,
        input  cr_ready_i,
        output cd_valid_o, cd_data_o, cd_last_o,
        input  cd_ready_i,
        output lookup_req_o, lookup_addr_o, lookup_snoop_o,
        input  lookup_gnt_i, lookup_rvalid_i, lookup_hit_i, lookup_dirty_i,
        input  lookup_shared_i, lookup_line_i,
        output busy_o
    );

    modport master (
        output ac_valid_i, ac_addr_i, ac_snoop_i,
        input  ac_ready_o,
        input  cr_valid_o, cr_resp_o,
        output cr_ready_i,
        input  cd_valid_o, cd_data_o, cd_last_o,
        output cd_ready_i,
        input  lookup_req_o, lookup_addr_o, lookup_snoop_o,
        output lookup_gnt_i, lookup_rvalid_i, lookup_hit_i, lookup_dirty_i,
        output lookup_shared_i, lookup_line_i,
        input  busy_o
    );
endinterface

// File: rtl/ace_snoop_sequencer.sv
// Handles one ACE snoop at a time: AC capture, single cache lookup, CRRESP generation
// and CD streaming of the line when data transfer is required.
module ace_snoop_sequencer #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineWidth = 128
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ace_snoop_sequencer_if.slave   bus
);
    localparam int Beats = LineWidth / DataWidth;
    localparam int CntW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int OffW  = $clog2(LineWidth / 8);
    localparam logic [AddrWidth-1:0] AlignMask = {{(AddrWidth-OffW){1'b1}}, {OffW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_WAIT   = 2'd2,
        S_SEND   = 2'd3
    } state_e;

    // Snoop types this sequencer looks up; anything else gets an immediate empty response.
    function automatic logic snoop_supported_f(input logic [3:0] snoop);
        logic sup;
        case (snoop)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0111, 4'b1000, 4'b1001, 4'b1101: sup = 1'b1;
            default:                            sup = 1'b0;
        endcase
        return sup;
    endfunction

    // CRRESP = {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
    function automatic logic [4:0] crresp_f(input logic [3:0] snoop, input logic hit,
                                            input logic dirty, input logic shared);
        logic dt, is, pd;
        logic [4:0] resp;
        case (snoop)
            4'b0000:                   begin dt = 1'b1;  is = 1'b1; pd = 1'b0;  end
            4'b0001, 4'b0010, 4'b0011: begin dt = 1'b1;  is = 1'b1; pd = dirty; end
            4'b0111:                   begin dt = 1'b1;  is = 1'b0; pd = dirty; end
            4'b1000:                   begin dt = dirty; is = 1'b1; pd = dirty; end
            4'b1001:                   begin dt = dirty; is = 1'b0; pd = dirty; end
            default:                   begin dt = 1'b0;  is = 1'b0; pd = 1'b0;  end
        endcase
        if (hit) begin
            resp = {~shared, is, pd, 1'b0, dt};
        end else begin
            resp = 5'b00000;
        end
        return resp;
    endfunction

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [3:0]           snoop_q, snoop_d;
    logic [4:0]           resp_q, resp_d;
    logic [LineWidth-1:0] line_q, line_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 cr_done_q, cr_done_d;
    logic                 cd_done_q, cd_done_d;

    logic ac_ready_s, ac_hs_s;
    logic cr_valid_s, cr_hs_s, cr_fin_s;
    logic cd_valid_s, cd_hs_s, cd_fin_s;
    logic last_s;

    assign ac_ready_s = (state_q == S_IDLE) && !rst_i;
    assign ac_hs_s    = ac_ready_s && bus.ac_valid_i;
    assign cr_valid_s = (state_q == S_SEND) && !cr_done_q;
    assign cd_valid_s = (state_q == S_SEND) && resp_q[0] && !cd_done_q;
    assign cr_hs_s    = cr_valid_s && bus.cr_ready_i;
    assign cd_hs_s    = cd_valid_s && bus.cd_ready_i;
    assign last_s     = (cnt_q == CntW'(Beats - 1));
    // A transaction without data counts its CD side as already finished.
    assign cr_fin_s   = cr_done_q || cr_hs_s;
    assign cd_fin_s   = !resp_q[0] || cd_done_q || (cd_hs_s && last_s);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ac_hs_s) begin
                    state_d = snoop_supported_f(bus.ac_snoop_i) ? S_LOOKUP : S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (bus.lookup_gnt_i) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_LOOKUP;
                end
            end
            S_WAIT: begin
                if (bus.lookup_rvalid_i) begin
                    state_d = S_SEND;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_SEND: begin
                if (cr_fin_s && cd_fin_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: capture on AC, load result in WAIT, track CR/CD progress in SEND.
    always_comb begin
        addr_d    = addr_q;
        snoop_d   = snoop_q;
        resp_d    = resp_q;
        line_d    = line_q;
        cnt_d     = cnt_q;
        cr_done_d = cr_done_q;
        cd_done_d = cd_done_q;
        if (ac_hs_s) begin
            addr_d    = bus.ac_addr_i & AlignMask;
            snoop_d   = bus.ac_snoop_i;
            resp_d    = 5'b00000;
            cnt_d     = '0;
            cr_done_d = 1'b0;
            cd_done_d = 1'b0;
        end else if ((state_q == S_WAIT) && bus.lookup_rvalid_i) begin
            resp_d = crresp_f(snoop_q, bus.lookup_hit_i, bus.lookup_dirty_i, bus.lookup_shared_i);
            line_d = bus.lookup_line_i;
        end else if (state_q == S_SEND) begin
            if (cr_hs_s) begin
                cr_done_d = 1'b1;
            end else begin
                cr_done_d = cr_done_q;
            end
            if (cd_hs_s && last_s) begin
                cd_done_d = 1'b1;
            end else if (cd_hs_s) begin
                cnt_d = cnt_q + CntW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q    <= '0;
            snoop_q   <= 4'b0000;
            resp_q    <= 5'b00000;
            line_q    <= '0;
            cnt_q     <= '0;
            cr_done_q <= 1'b0;
            cd_done_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            snoop_q   <= snoop_d;
            resp_q    <= resp_d;
            line_q    <= line_d;
            cnt_q     <= cnt_d;
            cr_done_q <= cr_done_d;
            cd_done_q <= cd_done_d;
        end
    end

    // Output decode; everything comes from registered state so stalls keep outputs stable.
    always_comb begin
        bus.ac_ready_o     = ac_ready_s;
        bus.cr_valid_o     = cr_valid_s;
        bus.cr_resp_o      = resp_q;
        bus.cd_valid_o     = cd_valid_s;
        bus.cd_data_o      = line_q[int'(cnt_q) * DataWidth +: DataWidth];
        bus.cd_last_o      = last_s;
        bus.lookup_req_o   = (state_q == S_LOOKUP);
        bus.lookup_addr_o  = addr_q;
        bus.lookup_snoop_o = snoop_q;
        bus.busy_o         = (state_q != S_IDLE);
    end
endmodule

// File: tb/tb_ace_snoop_sequencer.sv
// Directed bench for ace_snoop_sequencer: vector table of snoop/lookup cases plus
// hand-written backpressure and mid-transaction reset sequences.
module tb_ace_snoop_sequencer;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int LW    = 128;
    localparam int BEATS = LW / DW;
    localparam int NV    = 15;

    localparam logic [LW-1:0] L0 = 128'h1111111111111111_2222222222222222;
    localparam logic [LW-1:0] L1 = 128'hA5A5A5A50F0F0F0F_3C3C3C3C99999999;

    typedef struct {
        logic [3:0]    snoop;
        logic [AW-1:0] addr;
        logic          sup;
        logic          hit;
        logic          dirty;
        logic          shared;
        logic [LW-1:0] line;
        logic [4:0]    resp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   req_cycles = 0;
    vec_t vecs[NV];

    ace_snoop_sequencer_if #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)) bus();

    ace_snoop_sequencer #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.lookup_req_o === 1'b1) req_cycles++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_ac(input logic [3:0] snoop, input logic [AW-1:0] addr);
        bus.ac_valid_i = 1'b1;
        bus.ac_snoop_i = snoop;
        bus.ac_addr_i  = addr;
        step();
        bus.ac_valid_i = 1'b0;
    endtask

    task automatic give_result(input logic hit, input logic dirty, input logic shared,
                               input logic [LW-1:0] line);
        bus.lookup_rvalid_i = 1'b1;
        bus.lookup_hit_i    = hit;
        bus.lookup_dirty_i  = dirty;
        bus.lookup_shared_i = shared;
        bus.lookup_line_i   = line;
        step();
        bus.lookup_rvalid_i = 1'b0;
        bus.lookup_hit_i    = 1'b0;
        bus.lookup_dirty_i  = 1'b0;
        bus.lookup_shared_i = 1'b0;
        bus.lookup_line_i   = '0;
    endtask

    // One full transaction with immediate grant; CR ready only on the final beat so CR
    // and the last CD beat complete together.
    task automatic run_vec(input vec_t v);
        int            req0;
        logic [AW-1:0] al;
        al   = {v.addr[AW-1:4], 4'h0};
        req0 = req_cycles;
        chk("ac_ready_idle", bus.ac_ready_o, 1'b1);
        send_ac(v.snoop, v.addr);
        chk("busy_after_ac", bus.busy_o, 1'b1);
        if (v.sup) begin
            chk("lookup_req", bus.lookup_req_o, 1'b1);
            chk("lookup_addr", bus.lookup_addr_o, al);
            chk("lookup_snoop", bus.lookup_snoop_o, v.snoop);
            chk("cr_early", bus.cr_valid_o, 1'b0);
            bus.lookup_gnt_i = 1'b1;
            step();
            bus.lookup_gnt_i = 1'b0;
            chk("lookup_req_drop", bus.lookup_req_o, 1'b0);
            give_result(v.hit, v.dirty, v.shared, v.line);
        end else begin
            chk("no_lookup_unsup", bus.lookup_req_o, 1'b0);
        end
        chk("cr_valid", bus.cr_valid_o, 1'b1);
        chk("cr_resp", bus.cr_resp_o, v.resp);
        if (v.resp[0]) begin
            for (int b = 0; b < BEATS; b++) begin
                chk("cd_valid", bus.cd_valid_o, 1'b1);
                chk("cd_data", bus.cd_data_o, v.line[b*DW +: DW]);
                chk("cd_last", bus.cd_last_o, (b == BEATS - 1));
                chk("cr_hold", bus.cr_valid_o, 1'b1);
                bus.cd_ready_i = 1'b1;
                bus.cr_ready_i = (b == BEATS - 1);
                step();
            end
        end else begin
            chk("no_cd", bus.cd_valid_o, 1'b0);
            bus.cr_ready_i = 1'b1;
            step();
        end
        bus.cr_ready_i = 1'b0;
        bus.cd_ready_i = 1'b0;
        chk("idle_busy", bus.busy_o, 1'b0);
        chk("idle_ready", bus.ac_ready_o, 1'b1);
        chk("idle_cr", bus.cr_valid_o, 1'b0);
        chk("idle_cd", bus.cd_valid_o, 1'b0);
        chk("lookup_count", req_cycles - req0, v.sup ? 1 : 0);
    endtask

    initial begin
        int done;
        vecs[0]  = '{4'b0001, 64'h0000_0000_8000_004C, 1'b1, 1'b1, 1'b1, 1'b0, L0, 5'b11101};
        vecs[1]  = '{4'b1101, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 1'b1, 1'b1, L1, 5'b00000};
        vecs[2]  = '{4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, L1, 5'b00000};
        vecs[3]  = '{4'b0000, 64'h0000_0000_0000_0108, 1'b1, 1'b1, 1'b1, 1'b1, L1, 5'b01001};
        vecs[4]  = '{4'b0010, 64'h0000_0001_0000_0020, 1'b1, 1'b1, 1'b0, 1'b0, L0, 5'b11001};
        vecs[5]  = '{4'b0011, 64'h0000_0001_0000_0033, 1'b1, 1'b1, 1'b1, 1'b1, L1, 5'b01101};
        vecs[6]  = '{4'b0111, 64'h0000_00FF_0000_0040, 1'b1, 1'b1, 1'b1, 1'b0, L0, 5'b10101};
        vecs[7]  = '{4'b1000, 64'h0000_0000_0000_005F, 1'b1, 1'b1, 1'b1, 1'b1, L1, 5'b01101};
        vecs[8]  = '{4'b1000, 64'h0000_0000_0000_0060, 1'b1, 1'b1, 1'b0, 1'b0, L0, 5'b11000};
        vecs[9]  = '{4'b1001, 64'h0000_0000_0000_0071, 1'b1, 1'b1, 1'b1, 1'b0, L1, 5'b10101};
        vecs[10] = '{4'b1001, 64'h0000_0000_0000_0080, 1'b1, 1'b1, 1'b0, 1'b1, L0, 5'b00000};
        vecs[11] = '{4'b1101, 64'h0000_0000_0000_0090, 1'b1, 1'b1, 1'b0, 1'b0, L1, 5'b10000};
        vecs[12] = '{4'b0101, 64'h0000_0000_0000_00A0, 1'b0, 1'b1, 1'b1, 1'b0, L0, 5'b00000};
        vecs[13] = '{4'b1111, 64'h0000_0000_0000_00B0, 1'b0, 1'b1, 1'b1, 1'b0, L1, 5'b00000};
        vecs[14] = '{4'b0001, 64'h0000_0000_0000_00C0, 1'b1, 1'b0, 1'b1, 1'b1, L0, 5'b00000};

        bus.ac_valid_i = 1'b0; bus.ac_addr_i = '0; bus.ac_snoop_i = 4'b0000;
        bus.cr_ready_i = 1'b0; bus.cd_ready_i = 1'b0;
        bus.lookup_gnt_i = 1'b0; bus.lookup_rvalid_i = 1'b0;
        bus.lookup_hit_i = 1'b0; bus.lookup_dirty_i = 1'b0; bus.lookup_shared_i = 1'b0;
        bus.lookup_line_i = '0;

        // Reset state.
        step();
        step();
        chk("rst_ac_ready", bus.ac_ready_o, 1'b0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_cr_valid", bus.cr_valid_o, 1'b0);
        chk("rst_cd_valid", bus.cd_valid_o, 1'b0);
        chk("rst_lookup_req", bus.lookup_req_o, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.ac_ready_o, 1'b1);
        step();

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Backpressure: slow grant, stray rvalid outside WAIT, CR stalled 5 cycles, CD toggling.
        send_ac(4'b0001, 64'h0000_0000_ABCD_1237);
        for (int c = 0; c < 2; c++) begin
            bus.lookup_rvalid_i = 1'b1;
            bus.lookup_hit_i    = 1'b1;
            step();
            chk("bp_lookup_hold", bus.lookup_req_o, 1'b1);
            chk("bp_lookup_addr", bus.lookup_addr_o, 64'h0000_0000_ABCD_1230);
            chk("bp_no_cr", bus.cr_valid_o, 1'b0);
        end
        bus.lookup_rvalid_i = 1'b0;
        bus.lookup_hit_i    = 1'b0;
        bus.lookup_gnt_i    = 1'b1;
        step();
        bus.lookup_gnt_i = 1'b0;
        step();
        chk("bp_wait_hold", bus.cr_valid_o, 1'b0);
        chk("bp_wait_busy", bus.busy_o, 1'b1);
        give_result(1'b1, 1'b1, 1'b1, L1);
        done = 0;
        for (int c = 0; c < 5; c++) begin
            bus.cr_ready_i = 1'b0;
            bus.cd_ready_i = (c % 2 == 1);
            chk("bp_cr_valid", bus.cr_valid_o, 1'b1);
            chk("bp_cr_resp", bus.cr_resp_o, 5'b01101);
            chk("bp_ac_ready", bus.ac_ready_o, 1'b0);
            chk("bp_cd_valid", bus.cd_valid_o, (done < BEATS));
            if (done < BEATS) begin
                chk("bp_cd_data", bus.cd_data_o, L1[done*DW +: DW]);
                chk("bp_cd_last", bus.cd_last_o, (done == BEATS - 1));
            end
            step();
            if (bus.cd_ready_i && done < BEATS) done++;
        end
        bus.cd_ready_i = 1'b0;
        chk("bp_cd_dropped", bus.cd_valid_o, 1'b0);
        chk("bp_still_busy", bus.ac_ready_o, 1'b0);
        bus.cr_ready_i = 1'b1;
        step();
        bus.cr_ready_i = 1'b0;
        chk("bp_exit_ready", bus.ac_ready_o, 1'b1);
        chk("bp_exit_busy", bus.busy_o, 1'b0);
        chk("bp_exit_cr", bus.cr_valid_o, 1'b0);

        // Reset while in WAIT, then a fresh transaction.
        send_ac(4'b0001, 64'h0000_0000_0000_0200);
        bus.lookup_gnt_i = 1'b1;
        step();
        bus.lookup_gnt_i = 1'b0;
        rst = 1'b1;
        bus.lookup_rvalid_i = 1'b1;
        bus.lookup_hit_i    = 1'b1;
        step();
        bus.lookup_rvalid_i = 1'b0;
        bus.lookup_hit_i    = 1'b0;
        chk("rstw_cr", bus.cr_valid_o, 1'b0);
        chk("rstw_cd", bus.cd_valid_o, 1'b0);
        chk("rstw_req", bus.lookup_req_o, 1'b0);
        chk("rstw_ready", bus.ac_ready_o, 1'b0);
        rst = 1'b0;
        #1;
        chk("rstw_ready_after", bus.ac_ready_o, 1'b1);
        run_vec(vecs[0]);

        // Reset in SEND after the first beat.
        send_ac(4'b0111, 64'h0000_0000_0000_0300);
        bus.lookup_gnt_i = 1'b1;
        step();
        bus.lookup_gnt_i = 1'b0;
        give_result(1'b1, 1'b1, 1'b0, L0);
        bus.cd_ready_i = 1'b1;
        step();
        bus.cd_ready_i = 1'b0;
        chk("rsts_beat1", bus.cd_data_o, L0[DW +: DW]);
        chk("rsts_last", bus.cd_last_o, 1'b1);
        rst = 1'b1;
        step();
        chk("rsts_cr", bus.cr_valid_o, 1'b0);
        chk("rsts_cd", bus.cd_valid_o, 1'b0);
        chk("rsts_busy", bus.busy_o, 1'b0);
        rst = 1'b0;
        #1;
        run_vec(vecs[3]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
